// File: rtl/mem_bist_ctrl_pkg.sv
// Shared definitions for the memory BIST controller: state encodings,
// the march data pattern and the pass-sequencing helper.
package mem_bist_ctrl_pkg;

  // 3-bit state encodings (legacy-compatible constants)
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_W0   = 3'd1;
  localparam logic [2:0] ST_R0   = 3'd2;
  localparam logic [2:0] ST_W1   = 3'd3;
  localparam logic [2:0] ST_R1   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_FAIL = 3'd6;

  // Pattern word for index idx: idx + offset, wrapping mod 2^32
  function automatic logic [31:0] bist_pattern(input logic [31:0] idx,
                                               input logic [31:0] offset);
    return idx + offset;
  endfunction

  // True for the four march passes (the states in which the test is running)
  function automatic logic is_pass_state(input logic [2:0] s);
    return (s == ST_W0) || (s == ST_R0) || (s == ST_W1) || (s == ST_R1);
  endfunction

  // State that follows a completed pass: W0 -> R0 -> W1 -> R1 -> DONE
  function automatic logic [2:0] next_pass(input logic [2:0] s);
    logic [2:0] n;
    case (s)
      ST_W0:   n = ST_R0;
      ST_R0:   n = ST_W1;
      ST_W1:   n = ST_R1;
      ST_R1:   n = ST_DONE;
      default: n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_bist_ctrl.sv
// Initiator-side march BIST controller for a data_memory port with
// synchronous write and combinational read. Runs write-P, read-P,
// write-~P, read-~P over N_WORDS locations and stops at the first
// mismatch, holding the failing address, expected word and read data.
//
// Run handshake: START is a request that is accepted on any rising edge
// where the controller is not BUSY (IDLE, DONE or FAIL). Acceptance is
// visible as BUSY=1 after that edge; BUSY then stays high for exactly
// 4*N_WORDS cycles unless a mismatch or RST ends the run early. START
// seen while BUSY is ignored; START held high in DONE/FAIL restarts at
// once. RST wins over START.
module mem_bist_ctrl
  import mem_bist_ctrl_pkg::*;
#(
  parameter int unsigned N_WORDS   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [31:0] ADDR_STEP = 32'd1,
  parameter logic [31:0] OFFSET    = 32'd3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAIL,
  output logic [31:0] FAIL_ADDR,
  output logic [31:0] FAIL_EXP,
  output logic [31:0] FAIL_DATA,
  output logic        MEM_WE,
  output logic [31:0] MEM_A,
  output logic [31:0] MEM_WD,
  input  logic [31:0] MEM_RD,
  output logic [2:0]  DBG_STATE
);

  localparam int unsigned IW = $clog2(N_WORDS + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_WORDS - 1);

  logic [2:0]    state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [31:0]   idx_w;
  logic [31:0]   cur_addr;
  logic [31:0]   pat;
  logic [31:0]   exp_word;
  logic          in_pass;
  logic          is_read;
  logic          inv_pass;
  logic          mismatch;
  logic          last_word;
  logic          cap_load;
  logic          cap_clear;

  // Datapath decode: address, pattern and read-compare for the current word
  always_comb begin
    idx_w     = 32'(idx);
    in_pass   = is_pass_state(state);
    is_read   = (state == ST_R0) || (state == ST_R1);
    inv_pass  = (state == ST_W1) || (state == ST_R1);
    cur_addr  = BASE_ADDR + idx_w * ADDR_STEP;
    pat       = bist_pattern(idx_w, OFFSET);
    exp_word  = inv_pass ? ~pat : pat;
    mismatch  = is_read && (MEM_RD != exp_word);
    last_word = (idx == LAST_IDX);
  end

  // Next-state and index sequencing
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cap_load  = 1'b0;
    cap_clear = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (START) begin
          state_nxt = ST_W0;
          idx_nxt   = '0;
          cap_clear = 1'b1;
        end
      end
      ST_W0, ST_R0, ST_W1, ST_R1: begin
        if (mismatch) begin
          // A mismatch on the last word still lands in FAIL
          state_nxt = ST_FAIL;
          idx_nxt   = '0;
          cap_load  = 1'b1;
        end else if (last_word) begin
          state_nxt = next_pass(state);
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State, index and failure-capture registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      idx       <= '0;
      FAIL_ADDR <= '0;
      FAIL_EXP  <= '0;
      FAIL_DATA <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (cap_clear) begin
        FAIL_ADDR <= '0;
        FAIL_EXP  <= '0;
        FAIL_DATA <= '0;
      end else if (cap_load) begin
        FAIL_ADDR <= cur_addr;
        FAIL_EXP  <= exp_word;
        FAIL_DATA <= MEM_RD;
      end
    end
  end

  // Outputs decoded from registered state only; MEM_RD never reaches MEM_*
  always_comb begin
    BUSY      = in_pass;
    DONE      = (state == ST_DONE);
    FAIL      = (state == ST_FAIL);
    MEM_WE    = (state == ST_W0) || (state == ST_W1);
    MEM_A     = in_pass ? cur_addr : 32'h0;
    MEM_WD    = in_pass ? exp_word : 32'h0;
    DBG_STATE = state;
  end

endmodule
